// File: rtl/wb_ps2_if.sv
// Wishbone classic bus bundle for wb_ps2; member names carry the slave's point of view.
// Single-cycle ack per request; the slave never stalls beyond one wait state.
interface wb_ps2_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [29:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wb_ps2.sv
// Receive-only PS/2 port on Wishbone: synchronise/filter lines, deframe 11-bit frames, queue bytes, level irq.
// Bus: ack one cycle after request, pop/clear in that same edge; a push into a full FIFO drops the byte and sets OVR.
module wb_ps2 #(
    parameter int FIFO_DEPTH = 16,
    parameter int FILTER     = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    ps2_clk,
    input  logic    ps2_dat,
    output logic    irq,
    wb_ps2_if.slave wb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------------------------------------------------------- input path
    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [1:0]    raw;
    logic [1:0]    filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          strobe;
    logic          fdat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
        end
    end

    assign raw = {dat_sync_q[1], clk_sync_q[1]};

    // Bit 0 is the clock line, bit 1 the data line; both see identical delay so data stays aligned to the strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER - 1)) begin
                    filt_q[i] <= raw[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign strobe = clk_prev_q & ~filt_q[0];
    assign fdat   = filt_q[1];

    // ---------------------------------------------------------------- deframer
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          push_q;
    logic [7:0]    push_dat_q;
    logic          perr_set_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            perr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;

            if (state_q == S_IDLE || strobe) tmo_q <= '0;
            else                             tmo_q <= tmo_q + 1'b1;

            if (state_q != S_IDLE && !strobe && tmo_q == TW'(TIMEOUT - 1)) begin
                state_q <= S_IDLE;
            end else if (strobe) begin
                case (state_q)
                    S_IDLE: begin
                        if (!fdat) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {fdat, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_PAR;
                    end
                    S_PAR: begin
                        par_q   <= fdat;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        // A bad stop bit means we are misaligned; drop the frame without flagging it.
                        if (fdat) begin
                            if (^{shift_q, par_q}) begin
                                push_q     <= 1'b1;
                                push_dat_q <= shift_q;
                            end else begin
                                perr_set_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- bus decode
    logic        ack_q;
    logic [31:0] dat_q;
    logic        ien_q;
    logic        req;
    logic [1:0]  reg_adr;
    logic        wr_en;
    logic        pop;
    logic [31:0] rdata;
    logic        unused_bits;

    assign req         = wb.cyc_i & wb.stb_i & ~ack_q;
    assign reg_adr     = wb.adr_i[1:0];
    assign wr_en       = req & wb.we_i & wb.sel_i[0];
    assign unused_bits = ^{wb.adr_i[29:2], wb.sel_i[3:1], wb.dat_i[31:4], wb.dat_i[1]};

    // ---------------------------------------------------------------- FIFO and status flags
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovr_q;
    logic          perr_q;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic [7:0]    head;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign pop     = req & ~wb.we_i & (reg_adr == 2'd0) & ~empty;
    assign push_ok = push_q & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;

            // A new event in the same cycle as the clearing write wins, so it is never lost.
            if (push_q && !push_ok)                                   ovr_q <= 1'b1;
            else if (wr_en && reg_adr == 2'd1 && wb.dat_i[2])        ovr_q <= 1'b0;
            if (perr_set_q)                                           perr_q <= 1'b1;
            else if (wr_en && reg_adr == 2'd1 && wb.dat_i[3])        perr_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- register file
    always_comb begin
        rdata = '0;
        case (reg_adr)
            2'd0: rdata[8:0]  = {~empty, empty ? 8'h00 : head};
            2'd1: rdata[11:0] = {8'(count_q), perr_q, ovr_q, full, ~empty};
            2'd2: rdata[0]    = ien_q;
            default: rdata    = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            ien_q <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wb.we_i) ? rdata : '0;
            if (wr_en && reg_adr == 2'd2) ien_q <= wb.dat_i[0];
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = dat_q;
    assign irq      = ien_q & (~empty | ovr_q | perr_q);
endmodule

// File: tb/tb_wb_ps2.sv
// Directed bench for wb_ps2: PS/2 device model plus Wishbone master tasks, immediate-assert checks.
module tb_wb_ps2;
    localparam int TMO   = 200;
    localparam int QTR   = 10;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic irq;
    logic [31:0] rd;
    int checks = 0;
    int failures = 0;

    wb_ps2_if wb();

    wb_ps2 #(.FIFO_DEPTH(16), .FILTER(8), .TIMEOUT(TMO)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .irq     (irq),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        bit got = 1'b0;
        d = 32'hDEAD_BEEF;
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0;
        wb.adr_i = {28'd0, a}; wb.sel_i = 4'hF; wb.dat_i = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.ack_o) begin
                got = 1'b1;
                d = wb.dat_o;
            end
        end
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
        check("rd_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] v, input logic [3:0] s);
        bit got = 1'b0;
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1;
        wb.adr_i = {28'd0, a}; wb.sel_i = s; wb.dat_i = v;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.ack_o) got = 1'b1;
        end
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        check("wr_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic send_bit(input logic v);
        ps2_dat = v;
        repeat (QTR) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (QTR) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(stop);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        bit seen;
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        wb.adr_i = '0; wb.sel_i = '0; wb.dat_i = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", {31'd0, wb.ack_o}, 32'd0);
        check("rst_dat", wb.dat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        wb_read(2'd1, rd); check("rst_stat", rd, 32'h000);
        wb_read(2'd2, rd); check("rst_ctrl", rd, 32'h000);
        wb_read(2'd0, rd); check("rst_data", rd, 32'h000);
        @(posedge clk); #1;
        check("ack_pulse", {31'd0, wb.ack_o}, 32'd0);
        wb_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        wb_read(2'd3, rd); check("reg3_read", rd, 32'h000);

        // Single good frame.
        send_frame(8'h1C, 1'b0, 1'b1);
        wb_read(2'd1, rd); check("t1_stat", rd, 32'h011);
        check("t1_irq_masked", {31'd0, irq}, 32'd0);
        wb_read(2'd0, rd); check("t1_data", rd, 32'h11C);
        wb_read(2'd0, rd); check("t1_data_empty", rd, 32'h000);

        // Wrong parity bit on 0x5A (four ones, so a correct parity bit would be 1).
        send_frame(8'h5A, 1'b1, 1'b1);
        wb_read(2'd1, rd); check("t2_stat_perr", rd, 32'h008);
        wb_write(2'd1, 32'h8, 4'hE);
        wb_read(2'd1, rd); check("t2_sel0_gate", rd, 32'h008);
        wb_write(2'd1, 32'h8, 4'h1);
        wb_read(2'd1, rd); check("t2_stat_clr", rd, 32'h000);

        // Bad stop bit: silently dropped.
        send_frame(8'h33, 1'b0, 1'b0);
        wb_read(2'd1, rd); check("badstop_stat", rd, 32'h000);

        // Overflow: 17 frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
        wb_read(2'd1, rd); check("t3_stat_full", rd, 32'h107);
        for (int i = 0; i < 16; i++) begin
            wb_read(2'd0, rd);
            check("t3_data_order", rd, 32'h100 | (32'h10 + 32'(i)));
        end
        wb_read(2'd1, rd); check("t3_stat_ovr", rd, 32'h004);
        wb_write(2'd1, 32'h4, 4'h1);
        wb_read(2'd1, rd); check("t3_ovr_clr", rd, 32'h000);

        // Truncated frame, held idle past the timeout.
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        ps2_dat = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        wb_read(2'd1, rd); check("t4_stat_partial", rd, 32'h000);
        // Short clock glitches while data is low must not look like a start bit.
        ps2_dat = 1'b0;
        repeat (12) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0; repeat (4) @(negedge clk);
            ps2_clk = 1'b1; repeat (10) @(negedge clk);
        end
        ps2_dat = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b1);
        wb_read(2'd1, rd); check("t4_stat", rd, 32'h011);
        wb_read(2'd0, rd); check("t4_data", rd, 32'h1F0);

        // Interrupt timing.
        wb_write(2'd2, 32'h1, 4'h1);
        wb_read(2'd2, rd); check("t5_ctrl", rd, 32'h001);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h29 >> i) & 8'h1) != 0);
        send_bit(1'b0);
        check("t5_irq_before_stop", {31'd0, irq}, 32'd0);
        ps2_dat = 1'b1;
        repeat (QTR) @(negedge clk);
        ps2_clk = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(posedge clk); #1;
            if (irq) seen = 1'b1;
        end
        check("t5_irq_rise", {31'd0, seen}, 32'd1);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        wb_read(2'd0, rd); check("t5_data", rd, 32'h129);
        @(posedge clk); #1;
        check("t5_irq_fall", {31'd0, irq}, 32'd0);

        // Reset in the middle of a frame and a pending bus cycle.
        send_frame(8'hA1, 1'b0, 1'b1);
        send_frame(8'hB2, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        wb_read(2'd1, rd); check("t6_stat_pre", rd, 32'h031);
        check("t6_irq_pre", {31'd0, irq}, 32'd1);
        send_bit(1'b0); send_bit(1'b1);
        ps2_dat = 1'b0;
        repeat (QTR) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_rst_ack", {31'd0, wb.ack_o}, 32'd0);
        check("t6_rst_dat", wb.dat_o, 32'd0);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
        ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_irq_post", {31'd0, irq}, 32'd0);
        wb_read(2'd1, rd); check("t6_stat_post", rd, 32'h000);
        wb_read(2'd2, rd); check("t6_ctrl_post", rd, 32'h000);
        send_frame(8'h7E, 1'b0, 1'b1);
        wb_read(2'd0, rd); check("t6_data_post", rd, 32'h17E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
